// File: rtl/snax_tcdm_pkg.sv
// rtl/snax_tcdm_pkg.sv - shared TCDM request/response types and widths
package snax_tcdm_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } tcdm_q_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
    } tcdm_p_t;

endpackage

// File: rtl/snax_rsp_fifo.sv
// rtl/snax_rsp_fifo.sv - response buffer, head visible on data_o whenever non-empty
module snax_rsp_fifo #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [DataWidth-1:0]         data_i,
    input  logic                         pop_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);
    import snax_tcdm_pkg::*;

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;

    count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CntW'(Depth));

endmodule

// File: rtl/snax_tcdm_responder.sv
// rtl/snax_tcdm_responder.sv - TCDM port terminated on a 1-cycle-latency SRAM bank
module snax_tcdm_responder #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned MemAddrWidth = 10,
    parameter int unsigned RspDepth     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      tcdm_q_valid_i,
    output logic                      tcdm_q_ready_o,
    input  logic [AddrWidth-1:0]      tcdm_q_addr_i,
    input  logic                      tcdm_q_write_i,
    input  logic [DataWidth-1:0]      tcdm_q_data_i,
    input  logic [DataWidth/8-1:0]    tcdm_q_strb_i,
    output logic                      tcdm_p_valid_o,
    input  logic                      tcdm_p_ready_i,
    output logic [DataWidth-1:0]      tcdm_p_data_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MemAddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]      mem_wdata_o,
    output logic [DataWidth/8-1:0]    mem_be_o,
    input  logic [DataWidth-1:0]      mem_rdata_i
);
    import snax_tcdm_pkg::*;

    localparam int unsigned CntW = $clog2(RspDepth + 1);

    logic                 inflight_q, inflight_d;
    logic                 inflight_we_q, inflight_we_d;
    logic                 accept;
    logic [CntW:0]        credits_used;
    logic [DataWidth-1:0] rsp_datum;
    logic                 fifo_push, fifo_pop, fifo_empty;
    logic                 fifo_full_unused;
    logic [DataWidth-1:0] fifo_data;
    logic [CntW-1:0]      fifo_count;
    logic                 addr_bits_unused;

    // Outstanding = buffered + the one whose SRAM data arrives next cycle.
    assign credits_used   = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    assign tcdm_q_ready_o = credits_used < (CntW+1)'(RspDepth);
    assign accept         = tcdm_q_valid_i && tcdm_q_ready_o;

    assign mem_req_o   = accept;
    assign mem_we_o    = tcdm_q_write_i;
    assign mem_addr_o  = tcdm_q_addr_i[MemAddrWidth+1:2];
    assign mem_wdata_o = tcdm_q_data_i;
    assign mem_be_o    = tcdm_q_write_i ? tcdm_q_strb_i : '1;

    assign addr_bits_unused = ^{tcdm_q_addr_i[AddrWidth-1:MemAddrWidth+2], tcdm_q_addr_i[1:0]};

    always_comb begin
        inflight_d    = accept;
        inflight_we_d = accept && tcdm_q_write_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q    <= 1'b0;
            inflight_we_q <= 1'b0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_we_q <= inflight_we_d;
        end
    end

    assign rsp_datum = inflight_we_q ? '0 : mem_rdata_i;

    // SRAM data is only valid for one cycle: bypass when the buffer is empty,
    // otherwise it queues behind older responses.
    always_comb begin
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        tcdm_p_data_o = '0;
        if (fifo_empty) begin
            tcdm_p_data_o = inflight_q ? rsp_datum : '0;
            fifo_push     = inflight_q && !tcdm_p_ready_i;
        end else begin
            tcdm_p_data_o = fifo_data;
            fifo_pop      = tcdm_p_ready_i;
            fifo_push     = inflight_q;
        end
    end

    assign tcdm_p_valid_o = inflight_q || !fifo_empty;

    snax_rsp_fifo #(
        .Depth     (RspDepth),
        .DataWidth (DataWidth)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (rsp_datum),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// tb/tb_snax_tcdm_responder.sv - self-checking bench for snax_tcdm_responder
module tb_snax_tcdm_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [31:0] q_addr = '0;
    logic        q_write = 1'b0;
    logic [31:0] q_data = '0;
    logic [3:0]  q_strb = '0;
    logic        p_valid;
    logic        p_ready = 1'b0;
    logic [31:0] p_data;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;

    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_q   [$];
    logic [31:0] rsp_log [$];
    int          rsp_cyc [$];
    int          acc_cyc [$];
    bit          exp_ready;
    logic [31:0] word;

    snax_tcdm_responder dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tcdm_q_valid_i (q_valid),
        .tcdm_q_ready_o (q_ready),
        .tcdm_q_addr_i  (q_addr),
        .tcdm_q_write_i (q_write),
        .tcdm_q_data_i  (q_data),
        .tcdm_q_strb_i  (q_strb),
        .tcdm_p_valid_o (p_valid),
        .tcdm_p_ready_i (p_ready),
        .tcdm_p_data_o  (p_data),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_be_o       (mem_be),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single-port SRAM with 1-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Reference: outstanding responses form an ordered queue of at most 2.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_p_valid", {31'd0, p_valid}, 32'd0);
            chk("rst_q_ready", {31'd0, q_ready}, 32'd1);
            chk("rst_p_data", p_data, 32'd0);
        end else begin
            exp_ready = exp_q.size() < 2;
            chk("q_ready", {31'd0, q_ready}, {31'd0, exp_ready});
            chk("p_valid", {31'd0, p_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) chk("p_data", p_data, exp_q[0]);
            chk("mem_req", {31'd0, mem_req}, {31'd0, q_valid && exp_ready});
            if (exp_q.size() != 0 && p_ready) begin
                void'(exp_q.pop_front());
                rsp_log.push_back(p_data);
                rsp_cyc.push_back(cyc);
                hs_cnt++;
            end
            if (q_valid && exp_ready) begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, q_write});
                chk("mem_addr", {22'd0, mem_addr}, {22'd0, q_addr[11:2]});
                chk("mem_wdata", mem_wdata, q_data);
                chk("mem_be", {28'd0, mem_be}, q_write ? {28'd0, q_strb} : 32'hF);
                if (q_write) begin
                    word = ref_mem[q_addr[11:2]];
                    for (int b = 0; b < 4; b++)
                        if (q_strb[b]) word[8*b +: 8] = q_data[8*b +: 8];
                    ref_mem[q_addr[11:2]] = word;
                    exp_q.push_back(32'd0);
                end else begin
                    exp_q.push_back(ref_mem[q_addr[11:2]]);
                end
                acc_cnt++;
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rsp_log.delete();
        rsp_cyc.delete();
        acc_cyc.delete();
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit acc;
        int n;
        q_valid = 1'b1; q_write = wr; q_addr = addr; q_data = data; q_strb = strb;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = q_ready;
            tick();
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL req_timeout: got no accept expected accept of addr %h", addr);
        end
    endtask

    task automatic idle(input int n);
        q_valid = 1'b0;
        q_write = 1'b0;
        repeat (n) tick();
    endtask

    int acc0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Write then read, minimal latency
        p_ready = 1'b1;
        clear_logs();
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        idle(3);
        chk("t1_rsp_count", rsp_log.size(), 32'd2);
        if (rsp_log.size() == 2 && acc_cyc.size() == 2) begin
            chk("t1_write_rsp", rsp_log[0], 32'h0);
            chk("t1_read_rsp", rsp_log[1], 32'hDEADBEEF);
            chk("t1_write_lat", rsp_cyc[0] - acc_cyc[0], 32'd1);
            chk("t1_read_lat", rsp_cyc[1] - acc_cyc[1], 32'd1);
        end

        // Partial strobe merge
        clear_logs();
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
        do_req(1'b1, 32'h20, 32'h11223344, 4'b0101);
        do_req(1'b0, 32'h23, 32'h0, 4'h0);
        idle(3);
        chk("t2_rsp_count", rsp_log.size(), 32'd3);
        if (rsp_log.size() == 3) chk("t2_merged", rsp_log[2], 32'hAA22CC44);

        // Address aliasing: upper bits ignored
        clear_logs();
        do_req(1'b0, 32'h0000_1010, 32'h0, 4'h0);
        idle(3);
        if (rsp_log.size() == 1) chk("t2_alias", rsp_log[0], 32'hDEADBEEF);
        else chk("t2_alias_count", rsp_log.size(), 32'd1);

        // 64 back-to-back reads
        clear_logs();
        acc0 = acc_cnt;
        q_valid = 1'b1;
        q_write = 1'b0;
        for (int i = 0; i < 64; i++) begin
            q_addr = 32'(i * 4);
            tick();
        end
        idle(3);
        chk("t3_accepts", acc_cnt - acc0, 32'd64);
        chk("t3_rsp_count", rsp_log.size(), 32'd64);
        if (rsp_log.size() == 64) begin
            chk("t3_consecutive", rsp_cyc[63] - rsp_cyc[0], 32'd63);
            chk("t3_rsp4", rsp_log[4], 32'hDEADBEEF);
            chk("t3_rsp8", rsp_log[8], 32'hAA22CC44);
        end

        // Back-pressure: only 2 accepted, then drain
        clear_logs();
        acc0 = acc_cnt;
        p_ready = 1'b0;
        q_valid = 1'b1;
        q_addr = 32'h10;
        repeat (6) tick();
        @(negedge clk);
        chk("t4_accepts", acc_cnt - acc0, 32'd2);
        chk("t4_q_ready_low", {31'd0, q_ready}, 32'd0);
        tick();
        q_valid = 1'b0;
        p_ready = 1'b1;
        repeat (4) tick();
        chk("t4_drained", rsp_log.size(), 32'd2);
        if (rsp_log.size() == 2) begin
            chk("t4_rsp0", rsp_log[0], 32'hDEADBEEF);
            chk("t4_rsp1", rsp_log[1], 32'hDEADBEEF);
        end

        // Random traffic with 30% response ready
        acc0 = acc_cnt;
        hs_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            q_valid = 1'($urandom_range(0, 1));
            q_write = 1'($urandom_range(0, 1));
            q_addr  = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            q_data  = $urandom;
            q_strb  = 4'($urandom_range(0, 15));
            p_ready = ($urandom_range(0, 99) < 30);
            tick();
        end
        q_valid = 1'b0;
        p_ready = 1'b1;
        repeat (4) tick();
        chk("t5_all_returned", hs_cnt, acc_cnt - acc0);
        chk("t5_none_pending", exp_q.size(), 32'd0);

        // Reset with two buffered responses
        p_ready = 1'b0;
        q_valid = 1'b1;
        q_write = 1'b0;
        q_addr = 32'h20;
        repeat (3) tick();
        q_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_pre_valid", {31'd0, p_valid}, 32'd1);
        chk("t6_pre_ready", {31'd0, q_ready}, 32'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, p_valid}, 32'd0);
        chk("t6_async_ready", {31'd0, q_ready}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_logs();
        p_ready = 1'b1;
        repeat (5) tick();
        chk("t6_no_rsp", rsp_log.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
